// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract calculator controller.
// SAT_POS/SAT_NEG are only consumed when ADDSUB_SAT_EN is defined.
package addsub_pkg;

  localparam int DATA_W = 4;

  localparam logic [DATA_W-1:0] SAT_POS = 4'b0111;
  localparam logic [DATA_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  // Clamp value for a signed overflow; the sign of A decides the direction.
  function automatic logic [DATA_W-1:0] sat_value(input logic neg);
    return neg ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/addsub4.sv
// 4-bit two's complement adder/subtractor: s = a + (sub ? ~b + 1 : b),
// with raw carry-out and signed overflow (carry into MSB ^ carry out of MSB).
module addsub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] s,
  output logic       c4,
  output logic       v
);

  logic [3:0] bx;
  logic [3:0] low;
  logic [4:0] full;

  assign bx   = b ^ {4{sub}};
  assign low  = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, sub};
  assign full = {1'b0, a} + {1'b0, bx} + {4'b0000, sub};

  assign s  = full[3:0];
  assign c4 = full[4];
  assign v  = full[4] ^ low[3];

endmodule

// File: rtl/key_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous key.
// pulse is high for one cycle per low-to-high transition of key.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic s1;
  logic s2;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= key;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign pulse = s2 & ~prev;

endmodule

// File: rtl/addsub_calc_ctrl.sv
// Calculator sequencing controller around addsub4: capture A, capture B/op,
// execute, show. Define ADDSUB_SAT_EN to saturate the result on overflow.
module addsub_calc_ctrl
  import addsub_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] SW,
  input  logic              sub,
  input  logic              enter,
  input  logic              clear,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic [DATA_W-1:0] result,
  output logic              C4,
  output logic              V,
  output logic              result_valid,
  output logic [1:0]        state_code,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state;
  state_t            state_next;
  logic              enter_pulse;
  logic              op_sub;
  logic [DATA_W-1:0] sum;
  logic              c4_raw;
  logic              v_raw;
  logic [DATA_W-1:0] exec_result;

  logic              load_a;
  logic              chain_a;
  logic              load_b;
  logic              load_res;
  logic              wipe;

  key_edge u_key (
    .clk   (clk),
    .reset (reset),
    .key   (enter),
    .pulse (enter_pulse)
  );

  addsub4 u_alu (
    .a   (opA),
    .b   (opB),
    .sub (op_sub),
    .s   (sum),
    .c4  (c4_raw),
    .v   (v_raw)
  );

  always_comb begin
    exec_result = sum;
`ifdef ADDSUB_SAT_EN
    if (v_raw) exec_result = sat_value(opA[DATA_W-1]);
`else
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    chain_a    = 1'b0;
    load_b     = 1'b0;
    load_res   = 1'b0;
    wipe       = 1'b0;
    if (clear) begin
      state_next = IDLE;
      wipe       = 1'b1;
    end else begin
      unique case (state)
        IDLE: if (enter_pulse) begin
          load_a     = 1'b1;
          state_next = GET_B;
        end
        GET_B: if (enter_pulse) begin
          load_b     = 1'b1;
          state_next = EXEC;
        end
        EXEC: begin
          load_res   = 1'b1;
          state_next = SHOW;
        end
        SHOW: if (enter_pulse) begin
          chain_a    = 1'b1;
          state_next = GET_B;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // op_count survives clear; only reset zeroes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opA      <= '0;
      opB      <= '0;
      op_sub   <= 1'b0;
      result   <= '0;
      C4       <= 1'b0;
      V        <= 1'b0;
      op_count <= '0;
    end else if (wipe) begin
      opA    <= '0;
      opB    <= '0;
      op_sub <= 1'b0;
      result <= '0;
      C4     <= 1'b0;
      V      <= 1'b0;
    end else begin
      if (load_a)  opA <= SW;
      if (chain_a) opA <= result;
      if (load_b) begin
        opB    <= SW;
        op_sub <= sub;
      end
      if (load_res) begin
        result <= exec_result;
        C4     <= c4_raw;
        V      <= v_raw;
        if (op_count != '1) op_count <= op_count + CNT_W'(1);
      end
    end
  end

  assign result_valid = (state == SHOW);
  assign state_code   = state;

endmodule

// File: tb/tb_addsub_calc_ctrl.sv
// Self-checking bench for addsub_calc_ctrl: directed calculator scenarios plus
// randomized key/switch activity, compared every cycle against a behavioural model.
module tb_addsub_calc_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] SW;
  logic       sub;
  logic       enter;
  logic       clear;
  logic [3:0] opA;
  logic [3:0] opB;
  logic [3:0] result;
  logic       C4;
  logic       V;
  logic       result_valid;
  logic [1:0] state_code;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  addsub_calc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .SW           (SW),
    .sub          (sub),
    .enter        (enter),
    .clear        (clear),
    .opA          (opA),
    .opB          (opB),
    .result       (result),
    .C4           (C4),
    .V            (V),
    .result_valid (result_valid),
    .state_code   (state_code),
    .op_count     (op_count)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=idle,1=waiting for B,2=executing,3=showing.
  // A key press is seen two edges after enter is first sampled high.
  int  m_st;
  int  m_a, m_b, m_r, m_cnt;
  bit  m_sub, m_c, m_v;
  bit  e1, e2, e3, m_pulse;
  int  sa, sb, sr, su;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = 0; m_a = 0; m_b = 0; m_r = 0; m_cnt = 0;
      m_sub = 0; m_c = 0; m_v = 0;
      e1 = 0; e2 = 0; e3 = 0;
    end else begin
      m_pulse = e2 && !e3;
      e3 = e2; e2 = e1; e1 = enter;
      if (clear) begin
        m_st = 0; m_a = 0; m_b = 0; m_r = 0; m_c = 0; m_v = 0;
      end else begin
        case (m_st)
          0: if (m_pulse) begin m_a = SW; m_st = 1; end
          1: if (m_pulse) begin m_b = SW; m_sub = sub; m_st = 2; end
          2: begin
            sa = (m_a > 7) ? m_a - 16 : m_a;
            sb = (m_b > 7) ? m_b - 16 : m_b;
            sr = m_sub ? sa - sb : sa + sb;
            su = m_sub ? m_a + (15 - m_b) + 1 : m_a + m_b;
            m_v = (sr > 7) || (sr < -8);
            m_c = (su > 15);
            m_r = sr & 15;
`ifdef ADDSUB_SAT_EN
            if (m_v) m_r = (sa < 0) ? 8 : 7;
`endif
            if (m_cnt < CNT_MAX) m_cnt++;
            m_st = 3;
          end
          default: if (m_pulse) begin m_a = m_r; m_st = 1; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("state_code", 32'(state_code), 32'(m_st));
      check("opA", 32'(opA), 32'(m_a));
      check("opB", 32'(opB), 32'(m_b));
      check("result", 32'(result), 32'(m_r));
      check("C4", 32'(C4), 32'(m_c));
      check("V", 32'(V), 32'(m_v));
      check("result_valid", 32'(result_valid), 32'(m_st == 3));
      check("op_count", 32'(op_count), 32'(m_cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int sw, input bit s, input int hi, input int lo);
    SW = 4'(sw); sub = s; enter = 1'b1;
    tick(hi);
    enter = 1'b0;
    tick(lo);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int st, input int a, input int b,
                            input int r, input int c, input int v, input int cnt);
    check({tag, ".state"}, 32'(state_code), 32'(st));
    check({tag, ".opA"}, 32'(opA), 32'(a));
    check({tag, ".opB"}, 32'(opB), 32'(b));
    check({tag, ".result"}, 32'(result), 32'(r));
    check({tag, ".C4"}, 32'(C4), 32'(c));
    check({tag, ".V"}, 32'(V), 32'(v));
    check({tag, ".valid"}, 32'(result_valid), 32'(st == 3));
    check({tag, ".count"}, 32'(op_count), 32'(cnt));
  endtask

  int ovf_exp;

  initial begin
    reset = 1'b1; SW = '0; sub = 1'b0; enter = 1'b0; clear = 1'b0;
    #3;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    #9 reset = 1'b0;
    cmp_en = 1'b1;
    tick(2);

    // 3 + 2
    press(3, 0, 3, 3);
    check("idle_capture.state", 32'(state_code), 32'd1);
    press(2, 0, 3, 3);
    check_outs("add", 3, 3, 2, 5, 0, 0, 1);

    // chain: A <- 5, then 5 - 1
    press(0, 0, 3, 3);
    check("chain.state", 32'(state_code), 32'd1);
    check("chain.opA", 32'(opA), 32'd5);
    press(1, 1, 3, 3);
    check_outs("chain_sub", 3, 5, 1, 4, 1, 0, 2);

    // clear in GET_B colliding with an enter edge
    press(0, 0, 2, 2);
    SW = 4'd9; enter = 1'b1; clear = 1'b1;
    tick(4);
    clear = 1'b0; enter = 1'b0;
    tick(3);
    check_outs("clear", 0, 0, 0, 0, 0, 0, 2);

    // 3 - 2
    press(3, 0, 2, 2);
    press(2, 1, 2, 3);
    check_outs("sub_carry", 3, 3, 2, 1, 1, 0, 3);
    do_clear();

    // 2 - 3
    press(2, 0, 2, 2);
    press(3, 1, 2, 3);
    check_outs("sub_neg", 3, 2, 3, 15, 0, 0, 4);
    do_clear();

    // 5 + 4 overflows
`ifdef ADDSUB_SAT_EN
    ovf_exp = 7;
`else
    ovf_exp = 9;
`endif
    press(5, 0, 1, 2);
    press(4, 0, 1, 4);
    check_outs("overflow", 3, 5, 4, ovf_exp, 0, 1, 5);
    do_clear();

    // enter held high for 20 cycles: one capture only
    SW = 4'd7; enter = 1'b1;
    tick(20);
    enter = 1'b0;
    tick(3);
    check("held.state", 32'(state_code), 32'd1);
    check("held.opA", 32'(opA), 32'd7);
    do_clear();

    // reset while in EXEC, checked before any clock edge
    press(6, 0, 2, 2);
    SW = 4'd1; sub = 1'b0; enter = 1'b1;
    tick(3);
    check("pre_reset.state", 32'(state_code), 32'd2);
    #2 reset = 1'b1;
    #1;
    check_outs("async_reset", 0, 0, 0, 0, 0, 0, 0);
    enter = 1'b0;
    #3 reset = 1'b0;
    tick(2);

    // randomized sessions, including op_count saturation
    for (int i = 0; i < 220; i++) begin
      if ($urandom_range(0, 11) == 0) do_clear();
      else press($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 4), $urandom_range(1, 4));
    end
    tick(4);
    check("saturated_count", 32'(op_count), 32'(CNT_MAX));

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addsub_calc_ctrl.md
Name: addsub_calc_ctrl

Overview:
Sequencing controller for the existing 4-bit add/subtract datapath (addsub4). It turns the board's operand switches and one ENTER key into a calculator flow: capture A, capture B and the operation, execute, hold the result. It registers the result and the C4/V flags and supports chained operations, where the result becomes the next A. It sits between the board I/O and the existing decimal7decoder display path.

Parameters:
CNT_W, 8, width of completed-operation counter op_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
SW  input  4  operand data switches
sub  input  1  operation select, 0 = add, 1 = subtract; sampled when B is captured
enter  input  1  raw ENTER key, active-high level, asynchronous to clk
clear  input  1  synchronous clear to IDLE, active-high level
opA  output  4  registered operand A
opB  output  4  registered operand B
result  output  4  registered sum/difference
C4  output  1  registered carry/borrow-out of the last operation
V  output  1  registered signed-overflow flag of the last operation
result_valid  output  1  high while in SHOW
state_code  output  2  encoding: IDLE=0, GET_B=1, EXEC=2, SHOW=3
op_count  output  CNT_W  number of completed EXECs; saturates at all-ones

Behaviour:
- Reset: asynchronous and active-high, so it takes effect immediately. All outputs go to 0, the FSM enters IDLE, and the synchronizer flops clear.
- ENTER conditioning: two-flop synchronizer (s1, s2) plus a previous-value flop. enter_pulse = s2 & ~prev.
  - enter first sampled high at edge 0: pulse is high in the cycle after edge 1, and the FSM acts at edge 2.
  - Holding enter high produces exactly one pulse; enter must go low and then high again for another.
- FSM, one register update per edge:
  - IDLE: on enter_pulse, opA <= SW, go to GET_B.
  - GET_B: on enter_pulse, opB <= SW and op_sub <= sub, go to EXEC.
  - EXEC: one cycle, unconditional. result, C4 and V are loaded from addsub4(opA, opB, op_sub); op_count increments unless saturated; go to SHOW.
  - SHOW: result_valid = 1. On enter_pulse, chain: opA <= result and go to GET_B. opB, result and flags hold until the next EXEC.
- Latency: B capture to result_valid is 2 edges (GET_B->EXEC, then EXEC->SHOW).
- clear, any state:
  - Next edge: go to IDLE; opA, opB, result, C4, V and result_valid go to 0.
  - op_count is kept; only reset clears it.
  - clear has priority over a simultaneous enter_pulse.
- Arithmetic: 4-bit two's complement.
  - Subtract is A + ~B + 1.
  - C4 is the raw carry-out, so for subtract C4 = 1 means no borrow.
  - V = carry into MSB XOR carry out of MSB.
- Reset mid-EXEC: the result is discarded and op_count does not increment.
- enter_pulse in EXEC cannot occur, because the pulse needs at least 2 cycles of separation. Any pulse in EXEC is ignored.

Optional Feature:
ADDSUB_SAT_EN
- Defined: when V = 1 in EXEC, result saturates to 4'b0111 if opA[3] = 0, else 4'b1000. V still reports 1; C4 is unchanged.
- Undefined: result is the wrapped 4-bit value from addsub4.

Decomposition:
- Package addsub_pkg:
  - state_t enum (IDLE, GET_B, EXEC, SHOW), 2-bit, encoded as listed for state_code
  - localparams SAT_POS = 4'b0111, SAT_NEG = 4'b1000
  - localparam DATA_W = 4
- Natural sub-module: key_edge (2-flop synchronizer plus rising-edge detect, async active-high reset).
- The block instantiates the existing addsub4 unchanged. Display decoding stays outside this block.

Test Plan:
- Add: reset; SW=3, enter; SW=2, sub=0, enter -> 2 edges after B capture, result=5, C4=0, V=0, result_valid=1, state_code=3, op_count=1.
- Sub with carry: A=3, B=2, sub=1 -> result=1, C4=1, V=0.
- Negative result: A=2, B=3, sub=1 -> result=4'b1111, C4=0, V=0.
- Overflow: A=5, B=4, add -> V=1. Without ADDSUB_SAT_EN result=4'b1001; with ADDSUB_SAT_EN result=4'b0111.
- Chain and hold:
  - 3+2 -> SHOW with result=5.
  - Enter -> opA=5, state GET_B.
  - SW=1, sub=1, enter -> result=4, op_count=2.
  - enter held high 20 cycles -> exactly one capture.
- Clear and reset:
  - clear asserted in GET_B together with an enter edge -> IDLE; opA, opB, result and flags = 0; op_count unchanged.
  - reset asserted in EXEC -> all outputs 0 immediately, without waiting for a clock edge.
